rns_sequencer: RTL and testbench
================================

Name: rns_sequencer

Overview:
- Top-level controller for the RNS encoding datapath. Runs one RNS pass per modulus over a selectable number of moduli.
- For each modulus it fetches the modulus parameters (qm, k) from a parameter table and drives the RNS configuration inputs stably during the RNS reset-capture window.
- It arbitrates the multiplier/reduction resource inside UnifiedTransformation between RNS and the NTT engine, and hands each finished residue polynomial to the downstream consumer with a valid/ready handshake.

Parameters:
- LOGI, 4, modulus index width (up to 16 moduli)
- M, 17, width of qm field
- EXP_W, 12, width of scale (EXPONENT_BITS+1)
- ARM_CYCLES, 2, cycles rns_rst is held high per pass (min 1)
- TIMEOUT, 65535, max cycles in RUN before error (covers N=2^15 plus pipeline)

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- start  in  1  one-cycle pulse; begins sequence when IDLE
- num_moduli  in  LOGI+1  number of moduli to process (0 = complete immediately)
- scale_in  in  EXP_W  scale exponent, captured on start
- current_n_in  in  2  ring-size code (0:2^13, 1:2^14, 2:2^15), captured on start
- busy  out  1  high from accepted start until done
- done  out  1  one-cycle pulse at end of sequence
- error  out  1  sticky timeout flag; cleared by rst or accepted start
- param_rd_addr  out  LOGI  parameter table address
- param_rd_data  in  4+M  {k[3:0], qm[M-1:0]}; 1-cycle read latency
- rns_rst  out  1  reset/capture strobe to RNS
- rns_modulus_select  out  LOGI  current modulus index
- rns_scale  out  EXP_W  scale to RNS
- rns_current_n  out  2  ring size to RNS
- rns_current_k  out  4  k to RNS
- rns_qm  out  M  qm to RNS
- rns_done  in  1  RNS completion flag (level, low while rns_rst is high)
- ntt_req  in  1  NTT requests shared UnifiedTransformation resource
- ntt_grant  out  1  NTT owns shared resource
- ut_sel_rns  out  1  mux select: 1 = RNS drives the shared multiplier/reduction
- poly_valid  out  1  residue polynomial for poly_index is complete in BRAM
- poly_index  out  LOGI  modulus index of the handed-off polynomial
- poly_ready  in  1  consumer accepted polynomial

Behaviour:
- Reset values:
  - rns_rst=1 (keeps RNS parked).
  - busy, done, error, ntt_grant, ut_sel_rns, poly_valid = 0.
  - All index and config outputs = 0.
  - State IDLE.
- Mid-operation reset aborts immediately to these values. No handoff is issued for the interrupted modulus.
- States: IDLE, FETCH, WAIT_RES, ARM, RUN, HANDOFF, FINISH.
- IDLE:
  - On start, capture scale_in, current_n_in and num_moduli; clear error; set idx=0; set busy=1.
  - If num_moduli==0, go to FINISH. Otherwise go to FETCH.
  - start is ignored in every state other than IDLE.
- FETCH: param_rd_addr=idx. Next cycle, register param_rd_data into rns_current_k/rns_qm and set rns_modulus_select=idx. Then go to WAIT_RES.
- WAIT_RES:
  - Resource arbitration is non-preemptive, and the NTT has priority only while it already holds the grant.
  - If ntt_grant=1 and ntt_req=1, stay in WAIT_RES. Otherwise drop ntt_grant, set ut_sel_rns=1 and go to ARM.
- ARM:
  - rns_rst=1 for exactly ARM_CYCLES cycles.
  - All rns_* config outputs are stable from the first ARM cycle through the end of RUN.
  - Then rns_rst=0 and go to RUN.
- RUN:
  - rns_rst=0; the watchdog counter increments every cycle.
  - When rns_done=1, go to HANDOFF: ut_sel_rns=0, rns_rst=1, poly_valid=1, poly_index=idx.
  - rns_done is ignored in the first RUN cycle.
  - If the counter reaches TIMEOUT: set error=1, abandon the sequence with no handoff, and go to FINISH.
- HANDOFF:
  - poly_valid is held with poly_index stable until poly_ready=1. The transfer happens in the cycle where valid&&ready.
  - On transfer: idx+1. If idx+1==num_moduli, go to FINISH; else go to FETCH.
  - poly_ready while poly_valid=0 has no effect.
- FINISH: done=1 for one cycle, busy=0, go to IDLE.
- NTT arbitration when ut_sel_rns=0 (all states except ARM and RUN):
  - ntt_grant follows ntt_req, registered with 1-cycle latency.
  - ntt_grant and ut_sel_rns are never both 1.
- rns_rst stays high in IDLE, HANDOFF and FINISH so RNS never writes outside RUN.
- Timing example: num_moduli=1, ntt_req=0, ARM_CYCLES=2, RNS done after D cycles of RUN → done pulses (in cycles after start) at FETCH 2 + WAIT_RES 1 + ARM 2 + D + handoff ≥1 + FINISH.

Test Plan:
- num_moduli=3, qm/k table {0x1ABCD,3},{0x00F0F,5},{0x1FFFF,8}, poly_ready tied 1 → three passes with rns_modulus_select 0,1,2; rns_qm/rns_current_k match the table and are stable during each 2-cycle rns_rst window; exactly one done pulse.
- num_moduli=0 → done pulses 2 cycles after start; rns_rst never deasserts; no poly_valid.
- ntt_req held high with ntt_grant=1 when the sequencer reaches WAIT_RES, released after 50 cycles → ARM starts the cycle after release; ntt_grant and ut_sel_rns never overlap.
- poly_ready held low for 20 cycles after first poly_valid → poly_valid and poly_index=0 are held for those 20 cycles; FETCH of index 1 starts only after the transfer.
- rns_done tied 0 with TIMEOUT=100 → error=1 after 100 RUN cycles; done pulses; next start clears error.
- rst asserted in RUN of modulus 1 → all outputs return to reset values the next cycle; a subsequent start restarts at index 0.

Source files
------------

// File: rtl/rns_sequencer.sv
// Sequences one RNS pass per modulus, arbitrating the shared
// UnifiedTransformation multiplier with the NTT engine.
module rns_sequencer #(
  parameter int LOGI       = 4,
  parameter int M          = 17,
  parameter int EXP_W      = 12,
  parameter int ARM_CYCLES = 2,
  parameter int TIMEOUT    = 65535
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [LOGI:0]    num_moduli,
  input  logic [EXP_W-1:0] scale_in,
  input  logic [1:0]       current_n_in,
  output logic             busy,
  output logic             done,
  output logic             error,
  output logic [LOGI-1:0]  param_rd_addr,
  input  logic [M+3:0]     param_rd_data,
  output logic             rns_rst,
  output logic [LOGI-1:0]  rns_modulus_select,
  output logic [EXP_W-1:0] rns_scale,
  output logic [1:0]       rns_current_n,
  output logic [3:0]       rns_current_k,
  output logic [M-1:0]     rns_qm,
  input  logic             rns_done,
  input  logic             ntt_req,
  output logic             ntt_grant,
  output logic             ut_sel_rns,
  output logic             poly_valid,
  output logic [LOGI-1:0]  poly_index,
  input  logic             poly_ready
);

  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] ARM_END = CW'(ARM_CYCLES - 1);
  localparam logic [CW-1:0] RUN_END = CW'(TIMEOUT - 1);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);
  localparam logic [LOGI:0] IDX_ONE = (LOGI+1)'(1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_WAIT_RES,
    S_ARM,
    S_RUN,
    S_HANDOFF,
    S_FINISH
  } state_e;

  state_e           state_q, state_d;
  logic             fetch_ph_q, fetch_ph_d;
  logic [LOGI-1:0]  idx_q, idx_d;
  logic [LOGI:0]    num_q, num_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             error_q, error_d;
  logic [LOGI-1:0]  addr_q, addr_d;
  logic             rns_rst_q, rns_rst_d;
  logic [LOGI-1:0]  sel_q, sel_d;
  logic [EXP_W-1:0] scale_q, scale_d;
  logic [1:0]       n_q, n_d;
  logic [3:0]       k_q, k_d;
  logic [M-1:0]     qm_q, qm_d;
  logic             grant_q, grant_d;
  logic             ut_sel_q, ut_sel_d;
  logic             pvalid_q, pvalid_d;
  logic [LOGI-1:0]  pindex_q, pindex_d;
  logic [LOGI:0]    idx_nxt;

  assign idx_nxt = {1'b0, idx_q} + IDX_ONE;

  always_comb begin
    state_d    = state_q;
    fetch_ph_d = fetch_ph_q;
    idx_d      = idx_q;
    num_d      = num_q;
    cnt_d      = cnt_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    error_d    = error_q;
    addr_d     = addr_q;
    rns_rst_d  = rns_rst_q;
    sel_d      = sel_q;
    scale_d    = scale_q;
    n_d        = n_q;
    k_d        = k_q;
    qm_d       = qm_q;
    grant_d    = ntt_req;
    ut_sel_d   = ut_sel_q;
    pvalid_d   = pvalid_q;
    pindex_d   = pindex_q;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          scale_d    = scale_in;
          n_d        = current_n_in;
          num_d      = num_moduli;
          error_d    = 1'b0;
          idx_d      = '0;
          addr_d     = '0;
          fetch_ph_d = 1'b0;
          busy_d     = 1'b1;
          state_d    = (num_moduli == '0) ? S_FINISH : S_FETCH;
        end
      end
      S_FETCH: begin
        fetch_ph_d = ~fetch_ph_q;
        if (fetch_ph_q) begin
          qm_d    = param_rd_data[M-1:0];
          k_d     = param_rd_data[M+3:M];
          sel_d   = idx_q;
          state_d = S_WAIT_RES;
        end
      end
      S_WAIT_RES: begin
        // NTT keeps the resource only if it already holds it
        if (grant_q && ntt_req) begin
          grant_d = 1'b1;
        end else begin
          grant_d  = 1'b0;
          ut_sel_d = 1'b1;
          cnt_d    = '0;
          state_d  = S_ARM;
        end
      end
      S_ARM: begin
        grant_d = 1'b0;
        if (cnt_q == ARM_END) begin
          cnt_d     = '0;
          rns_rst_d = 1'b0;
          state_d   = S_RUN;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      S_RUN: begin
        grant_d = 1'b0;
        cnt_d   = cnt_q + CNT_ONE;
        if (cnt_q != '0 && rns_done) begin
          ut_sel_d  = 1'b0;
          rns_rst_d = 1'b1;
          pvalid_d  = 1'b1;
          pindex_d  = idx_q;
          state_d   = S_HANDOFF;
        end else if (cnt_q == RUN_END) begin
          ut_sel_d  = 1'b0;
          rns_rst_d = 1'b1;
          error_d   = 1'b1;
          state_d   = S_FINISH;
        end
      end
      S_HANDOFF: begin
        if (pvalid_q && poly_ready) begin
          pvalid_d = 1'b0;
          idx_d    = idx_nxt[LOGI-1:0];
          if (idx_nxt >= num_q) begin
            state_d = S_FINISH;
          end else begin
            addr_d     = idx_nxt[LOGI-1:0];
            fetch_ph_d = 1'b0;
            state_d    = S_FETCH;
          end
        end
      end
      S_FINISH: begin
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      fetch_ph_q <= 1'b0;
      idx_q      <= '0;
      num_q      <= '0;
      cnt_q      <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      error_q    <= 1'b0;
      addr_q     <= '0;
      rns_rst_q  <= 1'b1;
      sel_q      <= '0;
      scale_q    <= '0;
      n_q        <= '0;
      k_q        <= '0;
      qm_q       <= '0;
      grant_q    <= 1'b0;
      ut_sel_q   <= 1'b0;
      pvalid_q   <= 1'b0;
      pindex_q   <= '0;
    end else begin
      state_q    <= state_d;
      fetch_ph_q <= fetch_ph_d;
      idx_q      <= idx_d;
      num_q      <= num_d;
      cnt_q      <= cnt_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      error_q    <= error_d;
      addr_q     <= addr_d;
      rns_rst_q  <= rns_rst_d;
      sel_q      <= sel_d;
      scale_q    <= scale_d;
      n_q        <= n_d;
      k_q        <= k_d;
      qm_q       <= qm_d;
      grant_q    <= grant_d;
      ut_sel_q   <= ut_sel_d;
      pvalid_q   <= pvalid_d;
      pindex_q   <= pindex_d;
    end
  end

  assign busy               = busy_q;
  assign done               = done_q;
  assign error              = error_q;
  assign param_rd_addr      = addr_q;
  assign rns_rst            = rns_rst_q;
  assign rns_modulus_select = sel_q;
  assign rns_scale          = scale_q;
  assign rns_current_n      = n_q;
  assign rns_current_k      = k_q;
  assign rns_qm             = qm_q;
  assign ntt_grant          = grant_q;
  assign ut_sel_rns         = ut_sel_q;
  assign poly_valid         = pvalid_q;
  assign poly_index         = pindex_q;

endmodule

// File: tb/tb_rns_sequencer.sv
// Directed bench for rns_sequencer: table-driven passes, arbitration,
// backpressure, watchdog timeout and mid-run reset.
module tb_rns_sequencer;

  localparam int LOGI  = 4;
  localparam int M     = 17;
  localparam int EXP_W = 12;

  logic             clk;
  logic             rst;
  logic             start;
  logic [LOGI:0]    num_moduli;
  logic [EXP_W-1:0] scale_in;
  logic [1:0]       current_n_in;
  logic             busy;
  logic             done;
  logic             error;
  logic [LOGI-1:0]  param_rd_addr;
  logic [M+3:0]     param_rd_data;
  logic             rns_rst;
  logic [LOGI-1:0]  rns_modulus_select;
  logic [EXP_W-1:0] rns_scale;
  logic [1:0]       rns_current_n;
  logic [3:0]       rns_current_k;
  logic [M-1:0]     rns_qm;
  logic             rns_done;
  logic             ntt_req;
  logic             ntt_grant;
  logic             ut_sel_rns;
  logic             poly_valid;
  logic [LOGI-1:0]  poly_index;
  logic             poly_ready;

  int vec = 0;
  int bad = 0;

  logic [M+3:0] ptab [16];
  int run_cnt = 0;
  bit rns_en;
  int rns_lat;

  rns_sequencer #(
    .LOGI(LOGI), .M(M), .EXP_W(EXP_W),
    .ARM_CYCLES(2), .TIMEOUT(100)
  ) dut (
    .clk(clk), .rst(rst), .start(start),
    .num_moduli(num_moduli), .scale_in(scale_in),
    .current_n_in(current_n_in), .busy(busy), .done(done),
    .error(error), .param_rd_addr(param_rd_addr),
    .param_rd_data(param_rd_data), .rns_rst(rns_rst),
    .rns_modulus_select(rns_modulus_select),
    .rns_scale(rns_scale), .rns_current_n(rns_current_n),
    .rns_current_k(rns_current_k), .rns_qm(rns_qm),
    .rns_done(rns_done), .ntt_req(ntt_req),
    .ntt_grant(ntt_grant), .ut_sel_rns(ut_sel_rns),
    .poly_valid(poly_valid), .poly_index(poly_index),
    .poly_ready(poly_ready)
  );

  always #5 clk = ~clk;

  // parameter ROM with 1-cycle latency and a simple RNS latency model
  always @(posedge clk) begin
    param_rd_data <= ptab[param_rd_addr];
    run_cnt <= rns_rst ? 0 : run_cnt + 1;
  end
  assign rns_done = rns_en && !rns_rst && (run_cnt >= rns_lat);

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    vec++;
    if (rns_rst !== 1'b1) begin
      bad++;
      $display("FAIL reset_rns_rst: got %b want 1", rns_rst);
    end
    vec++;
    if ({busy, done, error, ntt_grant, ut_sel_rns, poly_valid} !== 6'b0) begin
      bad++;
      $display("FAIL reset_flags: got %b want 000000",
               {busy, done, error, ntt_grant, ut_sel_rns, poly_valid});
    end
    vec++;
    if ({param_rd_addr, rns_modulus_select, poly_index, rns_current_k} !== 16'h0) begin
      bad++;
      $display("FAIL reset_idx: got %h want 0",
               {param_rd_addr, rns_modulus_select, poly_index, rns_current_k});
    end
    vec++;
    if ({rns_qm, rns_scale, rns_current_n} !== 31'h0) begin
      bad++;
      $display("FAIL reset_cfg: got %h want 0", {rns_qm, rns_scale, rns_current_n});
    end
    rst = 1'b0;
    tick();
    vec++;
    if ({rns_rst, busy} !== 2'b10) begin
      bad++;
      $display("FAIL idle_after_reset: got %b want 10", {rns_rst, busy});
    end
  endtask

  task automatic test_multi();
    int p, arm_n, dones, done_at;
    rns_en = 1'b1;
    rns_lat = 3;
    poly_ready = 1'b1;
    num_moduli = 5'd3;
    scale_in = 12'h5A5;
    current_n_in = 2'd2;
    start = 1'b1;
    tick();
    start = 1'b0;
    vec++;
    if (busy !== 1'b1) begin
      bad++;
      $display("FAIL multi_busy: got %b want 1", busy);
    end
    p = 0;
    arm_n = 0;
    dones = 0;
    done_at = -1;
    for (int i = 1; i <= 60; i++) begin
      start = (i == 15);
      tick();
      if (ut_sel_rns) begin
        if (rns_rst) arm_n++;
        vec++;
        if ({rns_modulus_select, rns_current_k, rns_qm} !== {p[3:0], ptab[p]}) begin
          bad++;
          $display("FAIL multi_cfg%0d: got %h want %h", p,
                   {rns_modulus_select, rns_current_k, rns_qm}, {p[3:0], ptab[p]});
        end
        vec++;
        if ({rns_scale, rns_current_n} !== {12'h5A5, 2'd2}) begin
          bad++;
          $display("FAIL multi_scale: got %h want %h",
                   {rns_scale, rns_current_n}, {12'h5A5, 2'd2});
        end
      end
      if (poly_valid) begin
        vec++;
        if (poly_index !== p[3:0]) begin
          bad++;
          $display("FAIL multi_pidx: got %0d want %0d", poly_index, p);
        end
        vec++;
        if (arm_n !== 2) begin
          bad++;
          $display("FAIL multi_arm_len: got %0d want 2", arm_n);
        end
        p++;
        arm_n = 0;
      end
      vec++;
      if ((ntt_grant & ut_sel_rns) !== 1'b0) begin
        bad++;
        $display("FAIL multi_overlap: got 1 want 0");
      end
      if (done) begin
        dones++;
        done_at = i;
      end
    end
    vec++;
    if (p !== 3) begin
      bad++;
      $display("FAIL multi_passes: got %0d want 3", p);
    end
    vec++;
    if (dones !== 1) begin
      bad++;
      $display("FAIL multi_dones: got %0d want 1", dones);
    end
    vec++;
    if (done_at !== 31) begin
      bad++;
      $display("FAIL multi_done_cycle: got %0d want 31", done_at);
    end
    vec++;
    if ({busy, error, rns_rst} !== 3'b001) begin
      bad++;
      $display("FAIL multi_end: got %b want 001", {busy, error, rns_rst});
    end
  endtask

  task automatic test_zero();
    num_moduli = 5'd0;
    start = 1'b1;
    tick();
    start = 1'b0;
    vec++;
    if ({busy, done, rns_rst} !== 3'b101) begin
      bad++;
      $display("FAIL zero_c1: got %b want 101", {busy, done, rns_rst});
    end
    tick();
    vec++;
    if ({busy, done, rns_rst} !== 3'b011) begin
      bad++;
      $display("FAIL zero_c2: got %b want 011", {busy, done, rns_rst});
    end
    for (int i = 0; i < 5; i++) begin
      tick();
      vec++;
      if ({done, rns_rst, poly_valid} !== 3'b010) begin
        bad++;
        $display("FAIL zero_idle: got %b want 010", {done, rns_rst, poly_valid});
      end
    end
  endtask

  task automatic test_ntt_arb();
    rns_lat = 3;
    poly_ready = 1'b1;
    num_moduli = 5'd1;
    ntt_req = 1'b1;
    tick();
    vec++;
    if (ntt_grant !== 1'b1) begin
      bad++;
      $display("FAIL arb_idle_grant: got %b want 1", ntt_grant);
    end
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 1; i <= 65; i++) begin
      ntt_req = (i <= 49) || (i >= 53 && i <= 60);
      tick();
      vec++;
      if ((ntt_grant & ut_sel_rns) !== 1'b0) begin
        bad++;
        $display("FAIL arb_overlap: got 1 want 0 at %0d", i);
      end
      if (i == 49) begin
        vec++;
        if ({ut_sel_rns, ntt_grant} !== 2'b01) begin
          bad++;
          $display("FAIL arb_hold: got %b want 01", {ut_sel_rns, ntt_grant});
        end
      end
      if (i == 50) begin
        vec++;
        if ({ut_sel_rns, ntt_grant, rns_rst} !== 3'b101) begin
          bad++;
          $display("FAIL arb_arm: got %b want 101", {ut_sel_rns, ntt_grant, rns_rst});
        end
      end
      if (i == 56) begin
        vec++;
        if ({poly_valid, ntt_grant} !== 2'b10) begin
          bad++;
          $display("FAIL arb_handoff: got %b want 10", {poly_valid, ntt_grant});
        end
      end
      if (i == 57) begin
        vec++;
        if (ntt_grant !== 1'b1) begin
          bad++;
          $display("FAIL arb_regrant: got %b want 1", ntt_grant);
        end
      end
      if (i == 58) begin
        vec++;
        if ({done, busy} !== 2'b10) begin
          bad++;
          $display("FAIL arb_done: got %b want 10", {done, busy});
        end
      end
    end
    ntt_req = 1'b0;
    tick();
  endtask

  task automatic test_backpressure();
    rns_lat = 3;
    poly_ready = 1'b0;
    num_moduli = 5'd2;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 1; i <= 45; i++) begin
      poly_ready = (i >= 29);
      tick();
      if (i >= 9 && i <= 28) begin
        vec++;
        if ({poly_valid, poly_index, param_rd_addr, rns_modulus_select} !== 13'h1000) begin
          bad++;
          $display("FAIL bp_hold%0d: got %h want 1000", i,
                   {poly_valid, poly_index, param_rd_addr, rns_modulus_select});
        end
      end
      if (i == 29) begin
        vec++;
        if ({poly_valid, param_rd_addr} !== 5'h01) begin
          bad++;
          $display("FAIL bp_fetch1: got %h want 01", {poly_valid, param_rd_addr});
        end
      end
      if (i == 32) begin
        vec++;
        if ({ut_sel_rns, rns_rst, rns_modulus_select, rns_current_k, rns_qm}
            !== {2'b11, 4'd1, ptab[1]}) begin
          bad++;
          $display("FAIL bp_arm1: got %h want %h",
                   {ut_sel_rns, rns_rst, rns_modulus_select, rns_current_k, rns_qm},
                   {2'b11, 4'd1, ptab[1]});
        end
      end
      if (i == 38) begin
        vec++;
        if ({poly_valid, poly_index} !== 5'h11) begin
          bad++;
          $display("FAIL bp_pv1: got %h want 11", {poly_valid, poly_index});
        end
      end
      if (i == 40) begin
        vec++;
        if (done !== 1'b1) begin
          bad++;
          $display("FAIL bp_done: got %b want 1", done);
        end
      end
    end
  endtask

  task automatic test_timeout();
    int runs, pvs;
    rns_en = 1'b0;
    poly_ready = 1'b1;
    num_moduli = 5'd2;
    start = 1'b1;
    tick();
    start = 1'b0;
    runs = 0;
    pvs = 0;
    for (int i = 1; i <= 110; i++) begin
      tick();
      if (!rns_rst) runs++;
      if (poly_valid) pvs++;
      if (i == 104) begin
        vec++;
        if ({error, rns_rst, ut_sel_rns} !== 3'b001) begin
          bad++;
          $display("FAIL to_last_run: got %b want 001", {error, rns_rst, ut_sel_rns});
        end
      end
      if (i == 105) begin
        vec++;
        if ({error, rns_rst, ut_sel_rns, poly_valid, busy} !== 5'b11001) begin
          bad++;
          $display("FAIL to_error: got %b want 11001",
                   {error, rns_rst, ut_sel_rns, poly_valid, busy});
        end
      end
      if (i == 106) begin
        vec++;
        if ({done, busy, error} !== 3'b101) begin
          bad++;
          $display("FAIL to_done: got %b want 101", {done, busy, error});
        end
      end
      if (i == 110) begin
        vec++;
        if ({error, busy, done} !== 3'b100) begin
          bad++;
          $display("FAIL to_sticky: got %b want 100", {error, busy, done});
        end
      end
    end
    vec++;
    if (runs !== 100) begin
      bad++;
      $display("FAIL to_run_cycles: got %0d want 100", runs);
    end
    vec++;
    if (pvs !== 0) begin
      bad++;
      $display("FAIL to_no_handoff: got %0d want 0", pvs);
    end
    rns_en = 1'b1;
    num_moduli = 5'd0;
    start = 1'b1;
    tick();
    start = 1'b0;
    vec++;
    if ({error, busy} !== 2'b01) begin
      bad++;
      $display("FAIL to_clear: got %b want 01", {error, busy});
    end
    tick();
    tick();
  endtask

  task automatic test_reset_mid();
    int pvs;
    rns_lat = 3;
    poly_ready = 1'b1;
    num_moduli = 5'd3;
    scale_in = 12'h0C3;
    current_n_in = 2'd1;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 1; i <= 15; i++) tick();
    vec++;
    if ({rns_rst, rns_modulus_select, ut_sel_rns} !== 6'b000011) begin
      bad++;
      $display("FAIL mid_in_run1: got %b want 000011",
               {rns_rst, rns_modulus_select, ut_sel_rns});
    end
    rst = 1'b1;
    tick();
    vec++;
    if ({busy, done, error, ntt_grant, ut_sel_rns, poly_valid, rns_rst} !== 7'b0000001) begin
      bad++;
      $display("FAIL mid_rst_flags: got %b want 0000001",
               {busy, done, error, ntt_grant, ut_sel_rns, poly_valid, rns_rst});
    end
    vec++;
    if ({param_rd_addr, rns_modulus_select, poly_index, rns_current_k,
         rns_qm, rns_scale, rns_current_n} !== 47'h0) begin
      bad++;
      $display("FAIL mid_rst_cfg: got %h want 0",
               {param_rd_addr, rns_modulus_select, poly_index, rns_current_k,
                rns_qm, rns_scale, rns_current_n});
    end
    rst = 1'b0;
    tick();
    num_moduli = 5'd2;
    start = 1'b1;
    tick();
    start = 1'b0;
    vec++;
    if ({busy, param_rd_addr} !== 5'h10) begin
      bad++;
      $display("FAIL mid_restart: got %h want 10", {busy, param_rd_addr});
    end
    pvs = 0;
    for (int i = 1; i <= 25; i++) begin
      tick();
      if (poly_valid) pvs++;
      if (i == 3) begin
        vec++;
        if ({rns_modulus_select, rns_current_k, rns_qm} !== {4'd0, ptab[0]}) begin
          bad++;
          $display("FAIL mid_cfg0: got %h want %h",
                   {rns_modulus_select, rns_current_k, rns_qm}, {4'd0, ptab[0]});
        end
      end
      if (i == 9 || i == 19) begin
        vec++;
        if ({poly_valid, poly_index} !== {1'b1, (i == 19) ? 4'd1 : 4'd0}) begin
          bad++;
          $display("FAIL mid_pidx: got %h at %0d", {poly_valid, poly_index}, i);
        end
      end
      if (i == 21) begin
        vec++;
        if (done !== 1'b1) begin
          bad++;
          $display("FAIL mid_done: got %b want 1", done);
        end
      end
    end
    vec++;
    if (pvs !== 2) begin
      bad++;
      $display("FAIL mid_handoffs: got %0d want 2", pvs);
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    clk = 1'b0;
    rst = 1'b1;
    start = 1'b0;
    num_moduli = '0;
    scale_in = '0;
    current_n_in = '0;
    ntt_req = 1'b0;
    poly_ready = 1'b0;
    rns_en = 1'b1;
    rns_lat = 3;
    for (int i = 0; i < 16; i++) ptab[i] = '0;
    ptab[0] = {4'd3, 17'h1ABCD};
    ptab[1] = {4'd5, 17'h00F0F};
    ptab[2] = {4'd8, 17'h1FFFF};
    test_reset();
    test_multi();
    test_zero();
    test_ntt_arb();
    test_backpressure();
    test_timeout();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vec, bad);
    $finish;
  end

endmodule
